// File: rtl/pipeline_id_fwd.sv
// pipeline_id_fwd: decode-stage datapath with register file, operand forwarding,
// load-use hazard detection and an ID/EX pipeline register (valid/ready).
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid / in_ready            decoded instruction handshake from id_decoder
//   in_rs1, in_rs2, in_use_rs1/2   source indices and whether each is really read
//   in_rd, in_is_load, in_ctrl,    destination, load flag, opaque control bundle,
//   in_imm                         extended immediate
//   wb_en / wb_rd / wb_data        register file write port (write-through on read)
//   mem_fwd_*                      result leaving MEM (bypass)
//   ex_fwd_*                       non-load result of the instruction in EX (bypass)
//   flush                          kill the instruction in ID and the ID/EX register
//   out_valid / out_ready          ID/EX register handshake to EX
//   out_rd, out_is_load, out_ctrl,
//   out_imm, out_src1, out_src2    registered instruction fields and operands
//   stall_cnt                      saturating count of load-use stall cycles
module pipeline_id_fwd #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned CTRL_W   = 8,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rs1,
  input  logic [RADDR_W-1:0] in_rs2,
  input  logic               in_use_rs1,
  input  logic               in_use_rs2,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_is_load,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               mem_fwd_en,
  input  logic [RADDR_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]    mem_fwd_data,
  input  logic               ex_fwd_en,
  input  logic [RADDR_W-1:0] ex_fwd_rd,
  input  logic [XLEN-1:0]    ex_fwd_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_is_load,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_src1,
  output logic [XLEN-1:0]    out_src2,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam bit               ZR      = (ZERO_REG != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [XLEN-1:0] regs [NREG];

  logic            rf_we;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [XLEN-1:0] op1, op2;
  logic            hazard;
  logic            load_en;

  logic               nxt_valid;
  logic [RADDR_W-1:0] nxt_rd;
  logic               nxt_is_load;
  logic [CTRL_W-1:0]  nxt_ctrl;
  logic [XLEN-1:0]    nxt_imm;
  logic [XLEN-1:0]    nxt_src1;
  logic [XLEN-1:0]    nxt_src2;
  logic [CNT_W-1:0]   nxt_cnt;

  // Register file write enable; register 0 is hardwired when ZERO_REG is set.
  assign rf_we = wb_en && !(ZR && wb_rd == '0) && (32'(wb_rd) < NREG);

  // Register file storage, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Raw register file reads; indices past NREG read as zero.
  always_comb begin
    rf_rd1 = '0;
    rf_rd2 = '0;
    if (32'(in_rs1) < NREG) rf_rd1 = regs[in_rs1];
    if (32'(in_rs2) < NREG) rf_rd2 = regs[in_rs2];
  end

  // Bypass selection: youngest producer wins, write-back covers the same-cycle write.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [RADDR_W-1:0] rs,
    input logic [XLEN-1:0]    rf_val
  );
    logic [XLEN-1:0] val;
    if (ZR && rs == '0) begin
      val = '0;
    end else if (ex_fwd_en && ex_fwd_rd == rs) begin
      val = ex_fwd_data;
    end else if (mem_fwd_en && mem_fwd_rd == rs) begin
      val = mem_fwd_data;
    end else if (wb_en && wb_rd == rs) begin
      val = wb_data;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  always_comb begin
    op1 = pick_operand(in_rs1, rf_rd1);
    op2 = pick_operand(in_rs2, rf_rd2);
  end

  // Load-use: a load in ID/EX cannot bypass its data to the next instruction in time.
  always_comb begin
    hazard = in_valid && out_valid && out_is_load && (out_rd != '0 || !ZR) &&
             ((in_use_rs1 && in_rs1 == out_rd) || (in_use_rs2 && in_rs2 == out_rd));
  end

  assign load_en  = !out_valid || out_ready;
  assign in_ready = flush || (load_en && !hazard);

  // Next-state for the ID/EX register and stall counter.
  always_comb begin
    nxt_valid   = out_valid;
    nxt_rd      = out_rd;
    nxt_is_load = out_is_load;
    nxt_ctrl    = out_ctrl;
    nxt_imm     = out_imm;
    nxt_src1    = out_src1;
    nxt_src2    = out_src2;
    nxt_cnt     = stall_cnt;

    if (flush) begin
      nxt_valid = 1'b0;
    end else if (load_en && hazard) begin
      nxt_valid = 1'b0;
    end else if (load_en && in_valid) begin
      nxt_valid   = 1'b1;
      nxt_rd      = in_rd;
      nxt_is_load = in_is_load;
      nxt_ctrl    = in_ctrl;
      nxt_imm     = in_imm;
      nxt_src1    = op1;
      nxt_src2    = op2;
    end else if (load_en) begin
      nxt_valid = 1'b0;
    end

    // Counts stall cycles but never wraps.
    if (hazard && !flush && stall_cnt != CNT_MAX) begin
      nxt_cnt = stall_cnt + CNT_W'(1);
    end
  end

  // ID/EX register and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_rd      <= '0;
      out_is_load <= 1'b0;
      out_ctrl    <= '0;
      out_imm     <= '0;
      out_src1    <= '0;
      out_src2    <= '0;
      stall_cnt   <= '0;
    end else begin
      out_valid   <= nxt_valid;
      out_rd      <= nxt_rd;
      out_is_load <= nxt_is_load;
      out_ctrl    <= nxt_ctrl;
      out_imm     <= nxt_imm;
      out_src1    <= nxt_src1;
      out_src2    <= nxt_src2;
      stall_cnt   <= nxt_cnt;
    end
  end

endmodule

// File: tb/tb_pipeline_id_fwd.sv
// Testbench for pipeline_id_fwd: directed scenarios plus randomized traffic,
// checked against a cycle-level reference model of the decode stage.
module tb_pipeline_id_fwd;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREG    = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned CTRL_W  = 8;
  localparam int unsigned CNT_W   = 5;
  localparam int          CNT_MAX = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               in_valid, in_ready;
  logic [RADDR_W-1:0] in_rs1, in_rs2, in_rd;
  logic               in_use_rs1, in_use_rs2, in_is_load;
  logic [CTRL_W-1:0]  in_ctrl;
  logic [XLEN-1:0]    in_imm;
  logic               wb_en, mem_fwd_en, ex_fwd_en;
  logic [RADDR_W-1:0] wb_rd, mem_fwd_rd, ex_fwd_rd;
  logic [XLEN-1:0]    wb_data, mem_fwd_data, ex_fwd_data;
  logic               flush;
  logic               out_valid, out_ready, out_is_load;
  logic [RADDR_W-1:0] out_rd;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [XLEN-1:0]    out_imm, out_src1, out_src2;
  logic [CNT_W-1:0]   stall_cnt;

  pipeline_id_fwd #(
    .XLEN(XLEN), .NREG(NREG), .RADDR_W(RADDR_W), .CTRL_W(CTRL_W),
    .ZERO_REG(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_is_load(in_is_load), .in_ctrl(in_ctrl), .in_imm(in_imm),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_is_load(out_is_load), .out_ctrl(out_ctrl),
    .out_imm(out_imm), .out_src1(out_src1), .out_src2(out_src2),
    .stall_cnt(stall_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: architectural registers and the ID/EX slot.
  logic [XLEN-1:0]    m_rf [NREG];
  logic               m_vld, m_ld;
  logic [RADDR_W-1:0] m_rd;
  logic [CTRL_W-1:0]  m_ctrl;
  logic [XLEN-1:0]    m_imm, m_s1, m_s2;
  int                 m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) m_rf[i] = '0;
    m_vld = 0; m_ld = 0; m_rd = '0; m_ctrl = '0;
    m_imm = '0; m_s1 = '0; m_s2 = '0; m_cnt = 0;
  endtask

  // Value an instruction in ID sees for register rs this cycle.
  function automatic logic [XLEN-1:0] ref_operand(input logic [RADDR_W-1:0] rs);
    if (rs == 0)                           return '0;
    if (ex_fwd_en  && ex_fwd_rd  == rs)    return ex_fwd_data;
    if (mem_fwd_en && mem_fwd_rd == rs)    return mem_fwd_data;
    if (wb_en      && wb_rd      == rs)    return wb_data;
    return m_rf[rs];
  endfunction

  task automatic idle();
    in_valid = 0; in_rs1 = '0; in_rs2 = '0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_rd = '0; in_is_load = 0; in_ctrl = '0; in_imm = '0;
    wb_en = 0; wb_rd = '0; wb_data = '0;
    mem_fwd_en = 0; mem_fwd_rd = '0; mem_fwd_data = '0;
    ex_fwd_en = 0; ex_fwd_rd = '0; ex_fwd_data = '0;
    flush = 0; out_ready = 1;
  endtask

  task automatic check_outputs();
    check("out_valid",   out_valid,   m_vld);
    check("out_rd",      out_rd,      m_rd);
    check("out_is_load", out_is_load, m_ld);
    check("out_ctrl",    out_ctrl,    m_ctrl);
    check("out_imm",     out_imm,     m_imm);
    check("out_src1",    out_src1,    m_s1);
    check("out_src2",    out_src2,    m_s2);
    check("stall_cnt",   stall_cnt,   64'(m_cnt));
  endtask

  // One clock with the currently driven inputs; model advances alongside.
  task automatic cycle();
    logic haz, can_take;
    logic [XLEN-1:0] s1, s2;
    #1;
    haz = in_valid && m_vld && m_ld && (m_rd != 0) &&
          ((in_use_rs1 && in_rs1 == m_rd) || (in_use_rs2 && in_rs2 == m_rd));
    can_take = !m_vld || out_ready;
    check("in_ready", in_ready, flush || (can_take && !haz));
    s1 = ref_operand(in_rs1);
    s2 = ref_operand(in_rs2);
    if (haz && !flush && m_cnt < CNT_MAX) m_cnt++;
    if (flush)                    m_vld = 0;
    else if (can_take && haz)     m_vld = 0;
    else if (can_take && in_valid) begin
      m_vld = 1; m_rd = in_rd; m_ld = in_is_load; m_ctrl = in_ctrl;
      m_imm = in_imm; m_s1 = s1; m_s2 = s2;
    end
    else if (can_take)            m_vld = 0;
    if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  logic [XLEN-1:0]   snap_s1, snap_imm;
  logic [CTRL_W-1:0] snap_ctrl;

  initial begin
    idle();
    model_reset();
    rst = 1;
    @(posedge clk); #1;
    check("rst_valid", out_valid, 0);
    check("rst_src1",  out_src1,  0);
    check("rst_cnt",   stall_cnt, 0);
    @(negedge clk);
    rst = 0;

    // Write x5, then read it next cycle.
    wb_en = 1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    cycle();
    idle();
    in_valid = 1; in_rs1 = 5'd5; in_use_rs1 = 1; in_rd = 5'd7; in_ctrl = 8'hA5; in_imm = 32'h10;
    cycle();
    check("wb_then_read", out_src1, 32'hDEAD_BEEF);

    // Same-cycle write and read of x6 is write-through.
    idle();
    in_valid = 1; in_rs1 = 5'd6; in_use_rs1 = 1;
    wb_en = 1; wb_rd = 5'd6; wb_data = 32'hDEAD_BEEF;
    cycle();
    check("wb_same_cycle", out_src1, 32'hDEAD_BEEF);

    // Writes to x0 are ignored.
    idle();
    wb_en = 1; wb_rd = 5'd0; wb_data = 32'h1234;
    cycle();
    idle();
    in_valid = 1; in_rs2 = 5'd0; in_use_rs2 = 1;
    cycle();
    check("x0_reads_zero", out_src2, 0);

    // Forwarding priority: EX over MEM over register file.
    idle();
    wb_en = 1; wb_rd = 5'd3; wb_data = 32'd1;
    cycle();
    idle();
    in_valid = 1; in_rs1 = 5'd3; in_use_rs1 = 1;
    ex_fwd_en = 1; ex_fwd_rd = 5'd3; ex_fwd_data = 32'd7;
    mem_fwd_en = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'd9;
    cycle();
    check("fwd_ex", out_src1, 7);
    ex_fwd_en = 0;
    cycle();
    check("fwd_mem", out_src1, 9);

    // Load-use: one bubble, then the load result arrives via MEM bypass.
    idle();
    in_valid = 1; in_is_load = 1; in_rd = 5'd4;
    cycle();
    idle();
    in_valid = 1; in_rs1 = 5'd4; in_use_rs1 = 1; in_rd = 5'd8;
    #1;
    check("lu_ready_low", in_ready, 0);
    cycle();
    check("lu_bubble", out_valid, 0);
    check("lu_cnt", stall_cnt, 1);
    mem_fwd_en = 1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'h55;
    cycle();
    check("lu_fwd", out_src1, 32'h55);

    // Back-pressure: EX not ready for three cycles keeps ID/EX frozen.
    snap_s1 = out_src1; snap_imm = out_imm; snap_ctrl = out_ctrl;
    idle();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_rs1 = 5'(i + 1); in_use_rs1 = 1; in_imm = 32'(i + 100);
      in_ctrl = 8'(i + 3);
      cycle();
    end
    check("bp_valid", out_valid, 1);
    check("bp_src1",  out_src1,  snap_s1);
    check("bp_imm",   out_imm,   snap_imm);
    check("bp_ctrl",  out_ctrl,  snap_ctrl);
    flush = 1;
    cycle();
    check("flush_valid", out_valid, 0);

    // Saturation: self-dependent loads stall every other cycle.
    idle();
    in_valid = 1; in_is_load = 1; in_rd = 5'd4; in_rs1 = 5'd4; in_use_rs1 = 1;
    for (int i = 0; i < 80; i++) cycle();
    check("cnt_sat", stall_cnt, CNT_MAX);

    // Reset in the middle of a stall clears everything at once.
    idle();
    in_valid = 1; in_is_load = 1; in_rd = 5'd9;
    cycle();
    idle();
    in_valid = 1; in_rs2 = 5'd9; in_use_rs2 = 1;
    cycle();
    #2;
    rst = 1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_cnt",   stall_cnt, 0);
    model_reset();
    idle();
    @(negedge clk);
    rst = 0;

    // Randomized traffic over a small register window to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_rs1       = 5'($urandom_range(0, 7));
      in_rs2       = 5'($urandom_range(0, 7));
      in_use_rs1   = 1'($urandom_range(0, 1));
      in_use_rs2   = 1'($urandom_range(0, 1));
      in_rd        = 5'($urandom_range(0, 7));
      in_is_load   = 1'($urandom_range(0, 1));
      in_ctrl      = 8'($urandom);
      in_imm       = $urandom;
      wb_en        = 1'($urandom_range(0, 1));
      wb_rd        = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      mem_fwd_en   = ($urandom_range(0, 3) == 0);
      mem_fwd_rd   = 5'($urandom_range(0, 7));
      mem_fwd_data = $urandom;
      ex_fwd_en    = ($urandom_range(0, 3) == 0);
      ex_fwd_rd    = 5'($urandom_range(0, 7));
      ex_fwd_data  = $urandom;
      flush        = ($urandom_range(0, 19) == 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
